// File: rtl/div_sched_if.sv
// Request/result bundle between the shared divider and its requesters.
interface div_sched_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NUM_W = 32,
  parameter int unsigned DEN_W = 20,
  parameter int unsigned QUO_W = 16
);
  logic [NREQ-1:0]       req;
  logic [NREQ*NUM_W-1:0] num;
  logic [NREQ*DEN_W-1:0] den;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic [QUO_W-1:0]      quo;
  logic                  sat;

  // Requester side
  modport master (
    output req, num, den,
    input  gnt, busy, done, quo, sat
  );

  // Divider side
  modport slave (
    input  req, num, den,
    output gnt, busy, done, quo, sat
  );
endinterface

// File: rtl/div_sched.sv
// Shared restoring divider with a round-robin scheduler. One quotient bit per cycle,
// saturating QUO_W-bit result, divide-by-zero reported through sat.
module div_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NUM_W = 32,
  parameter int unsigned DEN_W = 20,
  parameter int unsigned QUO_W = 16
) (
  input logic         clk,
  input logic         reset_n,
  div_sched_if.slave  bus
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {StIdle, StDiv, StDone, StRelease} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [QUO_W-1:0]   quo_q, quo_d;
  logic               sat_q, sat_d;
  // Dividend shifts out MSB-first while quotient bits shift in at the LSB,
  // so after NUM_W steps this register holds the full quotient.
  logic [NUM_W-1:0]   dvd_q, dvd_d;
  logic [DEN_W-1:0]   den_q, den_d;
  logic [DEN_W-1:0]   rem_q, rem_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               zero_q, zero_d;

  logic               found;
  logic [IdxW-1:0]    win, cidx;
  logic [NREQ-1:0]    win_oh;
  int unsigned        cand;
  logic [NUM_W-1:0]   sel_num;
  logic [DEN_W-1:0]   sel_den;
  logic [DEN_W:0]     rem_sh;
  logic               ge;
  logic [DEN_W-1:0]   rem_nxt;

  // Circular search for the first pending request at or after ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cidx  = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr_q) + k) % NREQ;
      cidx = IdxW'(cand);
      if (!found && bus.req[cidx]) begin
        found = 1'b1;
        win   = cidx;
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  // Select the winner's operands.
  always_comb begin
    sel_num = '0;
    sel_den = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IdxW'(i)) begin
        sel_num = bus.num[i*NUM_W +: NUM_W];
        sel_den = bus.den[i*DEN_W +: DEN_W];
      end
    end
  end

  // One restoring step; the difference is < den when taken, so DEN_W bits suffice.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[NUM_W-1]};
    ge      = (rem_sh >= {1'b0, den_q});
    rem_nxt = ge ? (rem_sh[DEN_W-1:0] - den_q) : rem_sh[DEN_W-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    quo_d   = quo_q;
    sat_d   = sat_q;
    dvd_d   = dvd_q;
    den_d   = den_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          idx_d   = win;
          gnt_d   = win_oh;
          busy_d  = 1'b1;
          dvd_d   = sel_num;
          den_d   = sel_den;
          rem_d   = '0;
          cnt_d   = CntW'(NUM_W);
          zero_d  = (sel_den == '0);
          state_d = (sel_den == '0) ? StDone : StDiv;
        end
      end
      StDiv: begin
        dvd_d = {dvd_q[NUM_W-2:0], ge};
        rem_d = rem_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d = gnt_q;
        if (zero_q || (|dvd_q[NUM_W-1:QUO_W])) begin
          quo_d = '1;
          sat_d = 1'b1;
        end else begin
          quo_d = dvd_q[QUO_W-1:0];
          sat_d = 1'b0;
        end
        state_d = StRelease;
      end
      StRelease: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = '0;
        ptr_d   = (idx_q == IdxW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      quo_q   <= '0;
      sat_q   <= 1'b0;
      dvd_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      sat_q   <= sat_d;
      dvd_q   <= dvd_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.quo  = quo_q;
  assign bus.sat  = sat_q;

endmodule
